// File: rtl/cacheline_adaptor.sv
// Cache line <-> memory burst adaptor.
// Converts one 256-bit line fill or write-back request from the cache
// into four 64-bit memory beats, and reassembles fill beats into a line.
//
// Handshake: the cache raises read_i/write_i in IDLE. The request is
// captured on that edge and ignored afterwards. The memory side sees
// read_o/write_o held high for the whole burst and acknowledges each
// 64-bit beat with a single-cycle resp_i. Cycles without resp_i stall
// everything, and gaps between beats may be any length. After the
// fourth beat, resp_o pulses for exactly one cycle (DONE) and the
// adaptor returns to IDLE.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] wline_q, wline_d;
  logic [255:0] rline_q, rline_d;

  // Bit offset of the current beat inside the line (k * 64).
  logic [7:0]   lane_off;
  assign lane_off = {cnt_q, 6'd0};

  // Next-state, beat counter and data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        // Write-back wins over a simultaneous fill request.
        if (write_i) begin
          state_d = WRITE;
          addr_d  = address_i;
          wline_d = line_i;
          cnt_d   = 2'd0;
        end else if (read_i) begin
          state_d = READ;
          addr_d  = address_i;
          cnt_d   = 2'd0;
        end
      end
      READ: begin
        if (resp_i) begin
          rline_d[lane_off +: 64] = burst_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        // Requests still high here are not sampled; only IDLE starts a transfer.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also clears any partial fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      wline_q <= 256'd0;
      rline_q <= 256'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  // Outputs decode directly from registered state so they never glitch
  // with cache-side inputs.
  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = (read_o || write_o) ? {addr_q[31:5], 5'd0} : 32'd0;
  assign burst_o   = write_o ? wline_q[lane_off +: 64] : 64'd0;
  assign line_o    = rline_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios plus a
// randomized transfer loop, checked against a transaction-level model.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: line_o value expected at each resp_o pulse.
  logic [255:0] exp_q[$];
  // Model of the line last assembled by a completed fill (0 after reset).
  logic [255:0] last_line;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_chk(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [63:0] bo, input logic rsp);
    chk({tag, ".read_o"},    256'(read_o),    256'(rd));
    chk({tag, ".write_o"},   256'(write_o),   256'(wr));
    chk({tag, ".address_o"}, 256'(address_o), 256'(addr));
    chk({tag, ".burst_o"},   256'(burst_o),   256'(bo));
    chk({tag, ".resp_o"},    256'(resp_o),    256'(rsp));
  endtask

  // Scoreboard monitor: every resp_o pulse must match a completed transfer.
  always @(negedge clk) begin
    if (resp_o === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 256'd1, 256'd0);
      else chk("sb_line_o", line_o, exp_q.pop_front());
    end
  end

  // Idle cycles with stray resp_i that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      read_i    = 1'b0;
      write_i   = 1'b0;
      address_i = $urandom;
      resp_i    = 1'($urandom_range(1, 0));
      tick();
      cyc_chk("idle", 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    end
    resp_i = 1'b0;
  endtask

  // One transfer from IDLE. abort_after < 4 asserts rst after that many beats.
  task automatic xfer(input bit is_wr, input bit also_rd, input logic [31:0] addr,
                      input logic [255:0] wl, input bit directed, input int gmin,
                      input int gmax, input bit hold_req, input int abort_after);
    logic [255:0] rl;
    logic [31:0]  ea;
    logic [63:0]  b;
    logic [63:0]  exp_bo;
    int gap;
    rl = last_line;
    ea = addr & 32'hFFFF_FFE0;
    write_i   = is_wr;
    read_i    = !is_wr || also_rd;
    address_i = addr;
    line_i    = wl;
    resp_i    = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == abort_after) begin
        rst    = 1'b1;
        resp_i = 1'($urandom_range(1, 0));
        tick();
        rst     = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b0;
        last_line = '0;
        cyc_chk("abort", 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
        chk("abort.line_o", line_o, 256'd0);
        return;
      end
      gap = $urandom_range(gmax, gmin);
      exp_bo = is_wr ? wl[k*64 +: 64] : 64'd0;
      for (int g = 0; g <= gap; g++) begin
        read_i    = 1'($urandom);
        write_i   = 1'($urandom);
        address_i = $urandom;
        line_i    = {8{$urandom}};
        resp_i    = (g == gap);
        b = directed ? {16{4'(k + 1)}} : {$urandom, $urandom};
        burst_i = b;
        cyc_chk(is_wr ? "write_beat" : "read_beat", !is_wr, is_wr, ea, exp_bo, 1'b0);
        if (g == gap && !is_wr) rl[k*64 +: 64] = b;
        tick();
      end
    end
    last_line = rl;
    exp_q.push_back(last_line);
    read_i  = hold_req ? 1'b1 : 1'($urandom);
    write_i = hold_req ? 1'b0 : 1'($urandom);
    resp_i  = 1'($urandom);
    cyc_chk("done", 1'b0, 1'b0, 32'd0, 64'd0, 1'b1);
    tick();
    cyc_chk("after_done", 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    chk("line_hold", line_o, last_line);
    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    last_line = '0;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    tick();
    tick();
    rst = 1'b0;
    cyc_chk("reset", 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    chk("reset.line_o", line_o, 256'd0);

    // Stray resp_i in IDLE
    idle(4);

    // Directed fill: address 0x1234, back-to-back beats 0x11.., 0x22.., ...
    xfer(1'b0, 1'b0, 32'h0000_1234, '0, 1'b1, 0, 0, 1'b0, 4);
    chk("fill_line", line_o, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    idle(2);

    // Directed write-back with 2-cycle gaps between beats
    xfer(1'b1, 1'b0, 32'h8000_00FF,
         {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 1'b0, 2, 2, 1'b0, 4);
    idle(1);

    // Simultaneous read and write: write wins
    xfer(1'b1, 1'b1, 32'hCAFE_F00D, {8{$urandom}}, 1'b0, 0, 1, 1'b0, 4);
    idle(1);

    // Reset after beat 2 of a read, then a normal read
    xfer(1'b0, 1'b0, 32'h0000_4040, '0, 1'b0, 0, 1, 1'b0, 2);
    idle(3);
    xfer(1'b0, 1'b0, 32'h0000_5A5A, '0, 1'b0, 0, 1, 1'b0, 4);

    // read_i held high through DONE: no restart from DONE
    xfer(1'b0, 1'b0, 32'h1357_9BDF, '0, 1'b0, 0, 2, 1'b1, 4);
    idle(1);

    // Randomized transfers
    for (int t = 0; t < 24; t++) begin
      xfer(1'($urandom), 1'($urandom), $urandom, {8{$urandom}}, 1'b0, 0, 3, 1'b0, 4);
      idle($urandom_range(2, 0));
    end

    idle(2);
    chk("sb_drain", 256'(exp_q.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
